// File: rtl/fab_reset_sequencer.sv
// -----------------------------------------------------------------------------
// fab_reset_sequencer
//
// Releases the fabric-side datapath reset domains (camera capture, frame
// buffer, LCD output, ...) one at a time once the fabric reset controller
// reports INIT_DONE and the fabric PLL has held lock for LOCK_FILTER cycles.
// Handles Flash*Freeze entry: drains the running domains, puts them back in
// reset and acknowledges on FF_DONE. Leaving freeze re-runs the full sequence.
//
// Ports
//   CLK_BASE        in   1            block clock
//   RESET_N         in   1            asynchronous active-low reset
//   INIT_DONE       in   1            fabric init complete (async level)
//   FPLL_LOCK       in   1            fabric PLL lock (async level)
//   FF_TO_START     in   1            Flash*Freeze entry request (async level)
//   DOMAIN_IDLE     in   NUM_DOMAINS  per-domain quiescent flags (CLK_BASE)
//   DOMAIN_RESET_N  out  NUM_DOMAINS  per-domain active-low resets
//   SEQ_DONE        out  1            all domains released, system running
//   FF_DONE         out  1            fabric frozen-safe acknowledge
//   FAULT           out  2            sticky: [0] lock lost, [1] drain timeout
//   STATE           out  3            current FSM state (debug)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module fab_reset_sequencer #(
  parameter int NUM_DOMAINS   = 3,
  parameter int STAGE_DELAY   = 16,
  parameter int LOCK_FILTER   = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                   CLK_BASE,
  input  logic                   RESET_N,
  input  logic                   INIT_DONE,
  input  logic                   FPLL_LOCK,
  input  logic                   FF_TO_START,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_IDLE,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
  output logic                   SEQ_DONE,
  output logic                   FF_DONE,
  output logic [1:0]             FAULT,
  output logic [2:0]             STATE
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int IDX_W = (NUM_DOMAINS > 1)   ? $clog2(NUM_DOMAINS)   : 1;
  localparam int LCW   = (LOCK_FILTER > 1)   ? $clog2(LOCK_FILTER)   : 1;
  localparam int DLW   = $clog2(STAGE_DELAY + 1);
  localparam int DCW   = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0]       IDX_ONE    = IDX_W'(1'b1);
  localparam logic [LCW-1:0]         LOCK_LAST  = LCW'(LOCK_FILTER - 1);
  localparam logic [LCW-1:0]         LOCK_ONE   = LCW'(1'b1);
  localparam logic [DLW-1:0]         DLY_LOAD   = DLW'(STAGE_DELAY);
  localparam logic [DLW-1:0]         DLY_ONE    = DLW'(1'b1);
  localparam logic [DCW-1:0]         DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
  localparam logic [DCW-1:0]         DRAIN_ONE  = DCW'(1'b1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE    = NUM_DOMAINS'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOCK_WAIT  = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_STAGE_WAIT = 3'd3,
    ST_RUN        = 3'd4,
    ST_DRAIN      = 3'd5,
    ST_FF_ACK     = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers (2 flops each)
  // ---------------------------------------------------------------------------
  logic [1:0] init_sync_q;
  logic [1:0] lock_sync_q;
  logic [1:0] ff_sync_q;
  logic       init_done_s;
  logic       fpll_lock_s;
  logic       ff_to_start_s;

  // Two-stage synchronizers for the asynchronous level inputs
  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      init_sync_q <= 2'b00;
      lock_sync_q <= 2'b00;
      ff_sync_q   <= 2'b00;
    end else begin
      init_sync_q <= {init_sync_q[0], INIT_DONE};
      lock_sync_q <= {lock_sync_q[0], FPLL_LOCK};
      ff_sync_q   <= {ff_sync_q[0], FF_TO_START};
    end
  end

  assign init_done_s   = init_sync_q[1];
  assign fpll_lock_s   = lock_sync_q[1];
  assign ff_to_start_s = ff_sync_q[1];

  // ---------------------------------------------------------------------------
  // State, counters and output registers
  // ---------------------------------------------------------------------------
  state_t                 state_q,      state_d;
  logic [IDX_W-1:0]       idx_q,        idx_d;
  logic [LCW-1:0]         lock_cnt_q,   lock_cnt_d;
  logic [DLW-1:0]         dly_cnt_q,    dly_cnt_d;
  logic [DCW-1:0]         drain_cnt_q,  drain_cnt_d;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q,  dom_rst_n_d;
  logic                   seq_done_q,   seq_done_d;
  logic                   ff_done_q,    ff_done_d;
  logic [1:0]             fault_q,      fault_d;
  logic                   lock_watch_s;

  // Lock loss only matters once the filter has passed and before freeze.
  assign lock_watch_s = (state_q == ST_RELEASE)    ||
                        (state_q == ST_STAGE_WAIT) ||
                        (state_q == ST_RUN)        ||
                        (state_q == ST_DRAIN);

  // Next-state, counter and output computation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lock_cnt_d  = '0;
    dly_cnt_d   = dly_cnt_q;
    drain_cnt_d = drain_cnt_q;
    dom_rst_n_d = dom_rst_n_q;
    seq_done_d  = seq_done_q;
    ff_done_d   = ff_done_q;
    fault_d     = fault_q;

    if ((state_q != ST_IDLE) && !init_done_s) begin
      // Loss of fabric init wins over everything.
      state_d     = ST_IDLE;
      dom_rst_n_d = '0;
      seq_done_d  = 1'b0;
      ff_done_d   = 1'b0;
    end else if (lock_watch_s && !fpll_lock_s) begin
      // PLL dropped while domains may be running: slam all resets.
      state_d     = ST_LOCK_WAIT;
      dom_rst_n_d = '0;
      seq_done_d  = 1'b0;
      fault_d     = fault_q | 2'b01;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dom_rst_n_d = '0;
          seq_done_d  = 1'b0;
          ff_done_d   = 1'b0;
          if (init_done_s) begin
            state_d = ST_LOCK_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_LOCK_WAIT: begin
          dom_rst_n_d = '0;
          seq_done_d  = 1'b0;
          ff_done_d   = 1'b0;
          // Consecutive-high filter: any low cycle restarts the count.
          if (fpll_lock_s) begin
            if (lock_cnt_q == LOCK_LAST) begin
              lock_cnt_d = lock_cnt_q;
            end else begin
              lock_cnt_d = lock_cnt_q + LOCK_ONE;
            end
          end else begin
            lock_cnt_d = '0;
          end

          if (ff_to_start_s) begin
            // Domains are already held in reset, so freeze is safe at once.
            state_d = ST_FF_ACK;
          end else if (fpll_lock_s && (lock_cnt_q == LOCK_LAST)) begin
            state_d     = ST_RELEASE;
            idx_d       = '0;
            dom_rst_n_d = DOM_ONE;
          end else begin
            state_d = ST_LOCK_WAIT;
          end
        end

        ST_RELEASE: begin
          // The reset for domain idx was dropped on entry to this state.
          state_d   = ST_STAGE_WAIT;
          dly_cnt_d = DLY_LOAD;
        end

        ST_STAGE_WAIT: begin
          // Counter runs STAGE_DELAY..1, so the state lasts STAGE_DELAY cycles.
          if (dly_cnt_q <= DLY_ONE) begin
            if (idx_q == IDX_LAST) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d     = ST_RELEASE;
              idx_d       = idx_q + IDX_ONE;
              dom_rst_n_d = dom_rst_n_q | (DOM_ONE << idx_d);
            end
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_ONE;
          end
        end

        ST_RUN: begin
          if (ff_to_start_s) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
            seq_done_d  = 1'b0;
          end else begin
            state_d    = ST_RUN;
            seq_done_d = 1'b1;
          end
        end

        ST_DRAIN: begin
          if (&DOMAIN_IDLE) begin
            state_d     = ST_FF_ACK;
            dom_rst_n_d = '0;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            // Domains never went quiet: freeze anyway and flag it.
            state_d     = ST_FF_ACK;
            dom_rst_n_d = '0;
            fault_d     = fault_q | 2'b10;
          end else if (!ff_to_start_s) begin
            // Request withdrawn before the drain finished: resume running.
            state_d    = ST_RUN;
            seq_done_d = 1'b1;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = drain_cnt_q + DRAIN_ONE;
          end
        end

        ST_FF_ACK: begin
          dom_rst_n_d = '0;
          seq_done_d  = 1'b0;
          if (ff_to_start_s) begin
            // Acknowledge rises one cycle after the resets are asserted.
            state_d   = ST_FF_ACK;
            ff_done_d = 1'b1;
          end else begin
            state_d   = ST_LOCK_WAIT;
            ff_done_d = 1'b0;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          dom_rst_n_d = '0;
          seq_done_d  = 1'b0;
          ff_done_d   = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered-output flops
  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      lock_cnt_q  <= '0;
      dly_cnt_q   <= '0;
      drain_cnt_q <= '0;
      dom_rst_n_q <= '0;
      seq_done_q  <= 1'b0;
      ff_done_q   <= 1'b0;
      fault_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lock_cnt_q  <= lock_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      dom_rst_n_q <= dom_rst_n_d;
      seq_done_q  <= seq_done_d;
      ff_done_q   <= ff_done_d;
      fault_q     <= fault_d;
    end
  end

  assign DOMAIN_RESET_N = dom_rst_n_q;
  assign SEQ_DONE       = seq_done_q;
  assign FF_DONE        = ff_done_q;
  assign FAULT          = fault_q;
  assign STATE          = state_q;

endmodule

// File: tb/tb_fab_reset_sequencer.sv
module tb_fab_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic       fpll_lock;
  logic       ff_to_start;
  logic [2:0] domain_idle;
  logic [2:0] dr;
  logic       seq_done;
  logic       ff_done;
  logic [1:0] fault;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] dr;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb_q[$];

  fab_reset_sequencer #(
    .NUM_DOMAINS  (3),
    .STAGE_DELAY  (16),
    .LOCK_FILTER  (8),
    .DRAIN_TIMEOUT(1024)
  ) dut (
    .CLK_BASE      (clk),
    .RESET_N       (rst_n),
    .INIT_DONE     (init_done),
    .FPLL_LOCK     (fpll_lock),
    .FF_TO_START   (ff_to_start),
    .DOMAIN_IDLE   (domain_idle),
    .DOMAIN_RESET_N(dr),
    .SEQ_DONE      (seq_done),
    .FF_DONE       (ff_done),
    .FAULT         (fault),
    .STATE         (state)
  );

  always #5 clk = ~clk;

  // Bounded waits; n counts negedges from the call.
  task automatic wait_dr_change(input int limit, output int n, output bit to);
    logic [2:0] prev;
    prev = dr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((dr === prev) && (n < limit));
    to = (dr === prev);
  endtask

  task automatic wait_seq(input logic val, input int limit, output int n, output bit to);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((seq_done !== val) && (n < limit));
    to = (seq_done !== val);
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, output int n, output bit to);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((state !== st) && (n < limit));
    to = (state !== st);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b0; fpll_lock = 1'b1; ff_to_start = 1'b0; domain_idle = 3'b000;
    repeat (3) @(negedge clk);
    total++; if (dr !== 3'b000) begin bad++; $display("FAIL reset_dr got=%b exp=000", dr); end
    total++; if (seq_done !== 1'b0 || ff_done !== 1'b0) begin bad++; $display("FAIL reset_flags got seq=%b ff=%b exp 0 0", seq_done, ff_done); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL reset_fault got=%b exp=00", fault); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (state !== 3'd0 || dr !== 3'b000) begin bad++; $display("FAIL idle_hold got state=%0d dr=%b exp 0 000", state, dr); end
  endtask

  task automatic test_power_up();
    int n; bit to; exp_t e;
    init_done = 1'b1;
    sb_q.push_back('{dr: 3'b001, lo: 10, hi: 12});
    sb_q.push_back('{dr: 3'b011, lo: 17, hi: 17});
    sb_q.push_back('{dr: 3'b111, lo: 17, hi: 17});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_dr_change(60, n, to);
      total++;
      if (to || dr !== e.dr || n < e.lo || n > e.hi) begin
        bad++; $display("FAIL pu_release got dr=%b after %0d cyc exp dr=%b in %0d..%0d", dr, n, e.dr, e.lo, e.hi);
      end
    end
    wait_seq(1'b1, 40, n, to);
    total++; if (to || n != 17) begin bad++; $display("FAIL pu_seq_done got %0d cyc exp 17", n); end
    total++; if (state !== 3'd4 || fault !== 2'b00) begin bad++; $display("FAIL pu_run got state=%0d fault=%b exp 4 00", state, fault); end
  endtask

  task automatic test_init_loss();
    init_done = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL initloss_state got=%0d exp=0", state); end
    total++; if (dr !== 3'b000 || seq_done !== 1'b0) begin bad++; $display("FAIL initloss_out got dr=%b seq=%b exp 000 0", dr, seq_done); end
  endtask

  task automatic test_lock_glitch();
    int n; bit to; exp_t e;
    init_done = 1'b1;
    repeat (6) @(negedge clk);
    fpll_lock = 1'b0;
    @(negedge clk);
    fpll_lock = 1'b1;
    sb_q.push_back('{dr: 3'b001, lo: 9, hi: 11});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_dr_change(40, n, to);
      total++;
      if (to || dr !== e.dr || n < e.lo || n > e.hi) begin
        bad++; $display("FAIL glitch_release got dr=%b after %0d cyc exp dr=%b in %0d..%0d", dr, n, e.dr, e.lo, e.hi);
      end
    end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL glitch_fault got=%b exp=00", fault); end
    wait_seq(1'b1, 100, n, to);
    total++; if (to) begin bad++; $display("FAIL glitch_seq_done got seq=%b exp 1", seq_done); end
  endtask

  task automatic test_lock_loss_stage();
    int n; bit to; exp_t e;
    init_done = 1'b0;
    repeat (4) @(negedge clk);
    init_done = 1'b1;
    wait_dr_change(40, n, to);
    wait_dr_change(40, n, to);
    repeat (5) @(negedge clk);
    fpll_lock = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dr !== 3'b000) begin bad++; $display("FAIL lockloss_dr got=%b exp=000", dr); end
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL lockloss_fault got=%b exp=01", fault); end
    total++; if (state !== 3'd1 || seq_done !== 1'b0) begin bad++; $display("FAIL lockloss_state got state=%0d seq=%b exp 1 0", state, seq_done); end
    fpll_lock = 1'b1;
    sb_q.push_back('{dr: 3'b001, lo: 9, hi: 11});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_dr_change(40, n, to);
      total++;
      if (to || dr !== e.dr || n < e.lo || n > e.hi) begin
        bad++; $display("FAIL lockloss_reseq got dr=%b after %0d cyc exp dr=%b in %0d..%0d", dr, n, e.dr, e.lo, e.hi);
      end
    end
    wait_seq(1'b1, 100, n, to);
    total++; if (to) begin bad++; $display("FAIL lockloss_seq_done got seq=%b exp 1", seq_done); end
  endtask

  task automatic test_ff_entry();
    int n; bit to; exp_t e;
    domain_idle = 3'b000;
    ff_to_start = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (state !== 3'd5 || seq_done !== 1'b0 || dr !== 3'b111) begin
      bad++; $display("FAIL ff_drain got state=%0d seq=%b dr=%b exp 5 0 111", state, seq_done, dr);
    end
    repeat (36) @(negedge clk);
    domain_idle = 3'b111;
    @(negedge clk);
    total++; if (state !== 3'd6 || dr !== 3'b000 || ff_done !== 1'b0) begin
      bad++; $display("FAIL ff_ack_entry got state=%0d dr=%b ffd=%b exp 6 000 0", state, dr, ff_done);
    end
    @(negedge clk);
    total++; if (ff_done !== 1'b1) begin bad++; $display("FAIL ff_done_rise got=%b exp=1", ff_done); end
    total++; if (fault !== 2'b01) begin bad++; $display("FAIL ff_fault got=%b exp=01", fault); end
    ff_to_start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ff_done !== 1'b0 || state !== 3'd1) begin bad++; $display("FAIL ff_exit got ffd=%b state=%0d exp 0 1", ff_done, state); end
    domain_idle = 3'b000;
    sb_q.push_back('{dr: 3'b001, lo: 7, hi: 9});
    sb_q.push_back('{dr: 3'b011, lo: 17, hi: 17});
    sb_q.push_back('{dr: 3'b111, lo: 17, hi: 17});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_dr_change(60, n, to);
      total++;
      if (to || dr !== e.dr || n < e.lo || n > e.hi) begin
        bad++; $display("FAIL ff_reseq got dr=%b after %0d cyc exp dr=%b in %0d..%0d", dr, n, e.dr, e.lo, e.hi);
      end
    end
    wait_seq(1'b1, 40, n, to);
    total++; if (to || n != 17) begin bad++; $display("FAIL ff_seq_done got %0d cyc exp 17", n); end
  endtask

  task automatic test_drain_timeout();
    int n; bit to;
    domain_idle = 3'b011;
    ff_to_start = 1'b1;
    wait_state(3'd5, 10, n, to);
    total++; if (to) begin bad++; $display("FAIL to_drain_entry got state=%0d exp 5", state); end
    wait_state(3'd6, 1100, n, to);
    total++; if (to || n != 1024) begin bad++; $display("FAIL to_drain_len got %0d cyc exp 1024", n); end
    total++; if (fault !== 2'b11 || dr !== 3'b000) begin bad++; $display("FAIL to_fault got fault=%b dr=%b exp 11 000", fault, dr); end
    @(negedge clk);
    total++; if (ff_done !== 1'b1) begin bad++; $display("FAIL to_ff_done got=%b exp=1", ff_done); end
    ff_to_start = 1'b0;
    domain_idle = 3'b000;
    wait_seq(1'b1, 100, n, to);
    total++; if (to || fault !== 2'b11) begin bad++; $display("FAIL to_recover got seq=%b fault=%b exp 1 11", seq_done, fault); end
  endtask

  task automatic test_async_reset();
    int n; bit to; exp_t e;
    init_done = 1'b0;
    repeat (4) @(negedge clk);
    init_done = 1'b1;
    wait_dr_change(40, n, to);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (dr !== 3'b000 || state !== 3'd0) begin bad++; $display("FAIL arst_dr got dr=%b state=%0d exp 000 0", dr, state); end
    total++; if (fault !== 2'b00 || seq_done !== 1'b0 || ff_done !== 1'b0) begin
      bad++; $display("FAIL arst_flags got fault=%b seq=%b ffd=%b exp 00 0 0", fault, seq_done, ff_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back('{dr: 3'b001, lo: 10, hi: 12});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_dr_change(40, n, to);
      total++;
      if (to || dr !== e.dr || n < e.lo || n > e.hi) begin
        bad++; $display("FAIL arst_reseq got dr=%b after %0d cyc exp dr=%b in %0d..%0d", dr, n, e.dr, e.lo, e.hi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_init_loss();
    test_lock_glitch();
    test_lock_loss_stage();
    test_ff_entry();
    test_drain_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
